instr_prefetch_queue: RTL
=========================

Name: instr_prefetch_queue

Overview:
- Fetch stage between the instruction memory port and the instruction register stage.
- Drives sequential instruction reads and buffers returned words with their PCs in a small FIFO.
- Hands entries to the ir stage on a valid/ready handshake.
- Accepts redirects (branch mispredict / jalr resolution) that flush the buffer and restart fetch. Any in-flight memory read is drained safely first.

Parameters:
- DEPTH, 4, number of buffered entries (power of two, >=2)
- RESET_PC, 32'h4000_0000, fetch PC after reset

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- redirect_i  in  1  flush queue and restart fetch at redirect_pc_i
- redirect_pc_i  in  32  new fetch PC, word-aligned
- mem_read_o  out  1  instruction memory read request
- mem_addr_o  out  32  instruction memory address
- mem_resp_i  in  1  one-cycle pulse: mem_rdata_i valid for the request in flight
- mem_rdata_i  in  32  returned instruction word
- deq_valid_o  out  1  head entry valid
- deq_ready_i  in  1  ir stage accepts head entry this cycle
- deq_instr_o  out  32  head instruction
- deq_pc_o  out  32  PC of head instruction
- count_o  out  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Reset (async assert, sync release): state=FETCH, fetch_pc=RESET_PC, count=0, head/tail=0.
  - Outputs during reset: mem_read_o=0, mem_addr_o=RESET_PC, deq_valid_o=0, count_o=0.
- At most one memory request outstanding.
  - Once mem_read_o rises, mem_read_o and mem_addr_o stay constant until the cycle mem_resp_i=1.
  - mem_read_o is never dropped early.
- FSM states:
  - FETCH: mem_read_o = (count<DEPTH) | request_in_flight; mem_addr_o=fetch_pc.
    - On mem_resp_i: enqueue {mem_rdata_i, fetch_pc}; fetch_pc += 4 (mod 2^32).
    - The next request may start the cycle after the response.
  - DISCARD: mem_read_o=1, mem_addr_o=stale address.
    - On mem_resp_i: drop the data and go to FETCH. fetch_pc already holds the redirect PC.
- Redirect, highest priority, in any state:
  - Clear queue (count=0, head=tail).
  - fetch_pc=redirect_pc_i.
  - deq_valid_o is forced 0 in the redirect cycle.
  - If a request is in flight with no mem_resp_i this cycle, go to DISCARD.
  - If mem_resp_i coincides with redirect, drop the data and go to FETCH.
  - A redirect while already in DISCARD only updates fetch_pc.
- Dequeue: occurs when deq_valid_o & deq_ready_i; head advances with wrap at DEPTH.
- Enqueue and dequeue in the same cycle: count unchanged; legal even when count==DEPTH-1 or count==DEPTH.
- A full queue never receives a response: requests are only issued when count<DEPTH, and only one is outstanding.
  - An enqueue when full is an assertion failure.
- Empty queue: deq_valid_o=0; deq_instr_o/deq_pc_o hold the last head values (don't-care).
- Pointers are $clog2(DEPTH) bits wide and wrap naturally.

Optional Feature:
- Macro: IPQ_BYPASS_EN
- Defined: when count==0 and a response arrives in FETCH with no redirect, the response passes straight through.
  - Same cycle: deq_valid_o=1, deq_instr_o=mem_rdata_i, deq_pc_o=fetch_pc.
  - If deq_ready_i=1, the word is consumed and not written to the queue; otherwise it is enqueued normally.
- Not defined: the response is always written first; earliest deq_valid_o is the cycle after mem_resp_i.

Test Plan:
- Reset release, memory responds 1 cycle after each request.
  - Required: addresses 0x40000000, 0x40000004, 0x40000008 in order.
  - Required: deq_pc_o/deq_instr_o match each address/data pair.
- deq_ready_i held 0.
  - Required: exactly 4 responses accepted, count_o=4, mem_read_o=0 afterwards.
  - One dequeue: count_o=3, mem_read_o rises next cycle with addr 0x40000010.
- Redirect to 0x40000100 while a read of 0x40000008 is pending (resp 3 cycles later).
  - Required: mem_addr_o stays 0x40000008 until resp; data dropped; count_o=0.
  - Required: next request addr 0x40000100.
- Redirect to 0x40000200 in the same cycle as mem_resp_i.
  - Required: data not enqueued; next request 0x40000200; deq_valid_o=0 that cycle.
- count_o=2 with simultaneous enqueue and dequeue.
  - Required: count_o stays 2; FIFO order preserved across pointer wrap (16 instructions streamed).
- With IPQ_BYPASS_EN, empty queue, deq_ready_i=1, resp data 0x00000013.
  - Required: deq_valid_o=1 and deq_instr_o=0x00000013 in the resp cycle; count_o stays 0.

Source files
------------

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: sequential fetch into a small PC-tagged FIFO.
// Optional macro IPQ_BYPASS_EN: pass a response straight through when empty.
module instr_prefetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h4000_0000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     redirect_i,
    input  logic [31:0]              redirect_pc_i,
    output logic                     mem_read_o,
    output logic [31:0]              mem_addr_o,
    input  logic                     mem_resp_i,
    input  logic [31:0]              mem_rdata_i,
    output logic                     deq_valid_o,
    input  logic                     deq_ready_i,
    output logic [31:0]              deq_instr_o,
    output logic [31:0]              deq_pc_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic {
        S_FETCH,
        S_DISCARD
    } state_e;

    state_e        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic          req_q, req_d;
    logic [31:0]   addr_q, addr_d;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic [31:0]   instr_mem [DEPTH];
    logic [31:0]   pc_mem    [DEPTH];

    logic resp;
    logic q_valid;
    logic byp;
    logic enq;
    logic deq;

    // A response only counts while our own request is on the bus.
    assign resp    = mem_resp_i & req_q;
    assign q_valid = (count_q != '0);

`ifdef IPQ_BYPASS_EN
    assign byp = resp & (state_q == S_FETCH) & ~redirect_i & ~q_valid;
`else
    assign byp = 1'b0;
`endif

    assign deq_valid_o = (q_valid | byp) & ~redirect_i;
    assign deq_instr_o = byp ? mem_rdata_i : instr_mem[head_q];
    assign deq_pc_o    = byp ? fetch_pc_q  : pc_mem[head_q];

    // Queue dequeue only; a consumed bypass word never touches storage.
    assign deq = q_valid & deq_valid_o & deq_ready_i;
    assign enq = resp & (state_q == S_FETCH) & ~redirect_i
               & ~(byp & deq_ready_i);

    assign mem_read_o = req_q;
    assign mem_addr_o = addr_q;
    assign count_o    = count_q;

    // Next-state: FIFO bookkeeping, fetch FSM, then the request register.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        req_d      = req_q;
        addr_d     = addr_q;

        if (enq) tail_d = tail_q + PW'(1);
        if (deq) head_d = head_q + PW'(1);

        case ({enq, deq})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: ;
        endcase

        unique case (state_q)
            S_FETCH: begin
                if (resp && !redirect_i)
                    fetch_pc_d = fetch_pc_q + 32'd4;
            end
            S_DISCARD: begin
                // Stale word arrives: drop it, fetch_pc is already the target.
                if (resp) state_d = S_FETCH;
            end
            default: ;
        endcase

        if (redirect_i) begin
            fetch_pc_d = redirect_pc_i;
            head_d     = tail_q;
            tail_d     = tail_q;
            count_d    = '0;
            if (state_q == S_FETCH && req_q && !resp)
                state_d = S_DISCARD;
        end

        // An outstanding request is frozen until its response.
        if (req_q && !resp) begin
            req_d  = 1'b1;
            addr_d = addr_q;
        end else begin
            req_d  = (state_d == S_FETCH) && (count_d < FULL);
            addr_d = fetch_pc_d;
        end
    end

    // Control state with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_FETCH;
            fetch_pc_q <= RESET_PC;
            req_q      <= 1'b0;
            addr_q     <= RESET_PC;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

    // Entry storage needs no reset: count gates its visibility.
    always_ff @(posedge clk) begin
        if (enq) begin
            instr_mem[tail_q] <= mem_rdata_i;
            pc_mem[tail_q]    <= fetch_pc_q;
        end
    end

    a_no_full_enq: assert property (
        @(posedge clk) disable iff (!rst_n)
        !(enq && !deq && count_q == FULL)
    );

endmodule
